// File: rtl/mac_pkg.sv
// Shared helpers for the framed multiply-accumulate: signed range limits per width,
// round-half-up scaling and saturation, all evaluated on a 64-bit signed value.
package mac_pkg;

    function automatic logic signed [63:0] signed_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] signed_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    // Add half an LSB of the scaled result, then arithmetic shift (round half up).
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                       input int shift);
        if (shift <= 0) begin
            return value;
        end
        return (value + (64'sd1 <<< (shift - 1))) >>> shift;
    endfunction

    function automatic logic fits_signed(input logic signed [63:0] value, input int width);
        return (value >= signed_min(width)) && (value <= signed_max(width));
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width);
        if (value > signed_max(width)) begin
            return signed_max(width);
        end
        if (value < signed_min(width)) begin
            return signed_min(width);
        end
        return value;
    endfunction

endpackage

// File: rtl/mac_coefficient_bank.sv
// Coefficient storage: one write port and one registered read port.
// A read and write of the same address in one cycle returns the previous contents.
module mac_coefficient_bank #(
    parameter int NUM_TAPS          = 8,
    parameter int COEFFICIENT_WIDTH = 16,
    parameter int ADDRESS_WIDTH     = $clog2(NUM_TAPS)
) (
    input  logic                                clock,
    input  logic                                write_enable,
    input  logic [ADDRESS_WIDTH-1:0]            write_address,
    input  logic signed [COEFFICIENT_WIDTH-1:0] write_data,
    input  logic [ADDRESS_WIDTH-1:0]            read_address,
    output logic signed [COEFFICIENT_WIDTH-1:0] read_data
);

    logic signed [COEFFICIENT_WIDTH-1:0] bank [NUM_TAPS];

    // Contents deliberately survive reset so coefficients need loading only once.
    always_ff @(posedge clock) begin
        if (write_enable) begin
            bank[write_address] <= write_data;
        end
        read_data <= bank[read_address];
    end

endmodule

// File: rtl/multiply_accumulate_framed.sv
// Four-stage framed MAC: sample x coefficient products summed per frame, then rounded/scaled.
// Define MAC_SATURATE_EN to clamp out-of-range results instead of wrapping them.
module multiply_accumulate_framed
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int COEFFICIENT_WIDTH = 16,
    parameter int ACCUM_WIDTH       = 48,
    parameter int NUM_TAPS          = 8,
    parameter int OUTPUT_SHIFT      = 14
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic signed [DATA_WIDTH-1:0]        data_in,
    input  logic                                in_valid,
    input  logic                                in_last,
    input  logic                                coeff_write,
    input  logic [$clog2(NUM_TAPS)-1:0]         coeff_address,
    input  logic signed [COEFFICIENT_WIDTH-1:0] coefficient_in,
    output logic signed [DATA_WIDTH-1:0]        data_out,
    output logic signed [ACCUM_WIDTH-1:0]       carry_out,
    output logic                                out_valid,
    output logic                                overflow
);

    localparam int TAP_WIDTH     = $clog2(NUM_TAPS);
    localparam int PRODUCT_WIDTH = DATA_WIDTH + COEFFICIENT_WIDTH;

    logic [TAP_WIDTH-1:0]                tap;
    logic                                frame_end;
    logic                                s1_valid, s1_first, s1_last;
    logic signed [DATA_WIDTH-1:0]        s1_sample;
    logic signed [COEFFICIENT_WIDTH-1:0] s1_coeff;
    logic                                s2_valid, s2_first, s2_last;
    logic signed [PRODUCT_WIDTH-1:0]     s2_product;
    logic                                acc_done;
    logic signed [ACCUM_WIDTH-1:0]       accum;
    logic signed [63:0]                  rounded;
    logic signed [DATA_WIDTH-1:0]        next_data;
    logic                                next_overflow;

    // A frame closes on an explicit last marker or when the bank runs out of taps.
    assign frame_end = in_last || (tap == TAP_WIDTH'(NUM_TAPS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            tap <= '0;
        end else if (in_valid) begin
            tap <= frame_end ? '0 : tap + 1'b1;
        end
    end

    mac_coefficient_bank #(
        .NUM_TAPS          (NUM_TAPS),
        .COEFFICIENT_WIDTH (COEFFICIENT_WIDTH),
        .ADDRESS_WIDTH     (TAP_WIDTH)
    ) coefficient_bank (
        .clock         (clock),
        .write_enable  (coeff_write),
        .write_address (coeff_address),
        .write_data    (coefficient_in),
        .read_address  (tap),
        .read_data     (s1_coeff)
    );

    // Stage 1: the bank's registered read supplies the coefficient alongside the sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            s1_first <= in_valid && (tap == '0);
            s1_last  <= in_valid && frame_end;
        end
    end

    always_ff @(posedge clock) begin
        if (in_valid) begin
            s1_sample <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
        end
    end

    always_ff @(posedge clock) begin
        if (s1_valid) begin
            s2_product <= PRODUCT_WIDTH'(s1_sample) * PRODUCT_WIDTH'(s1_coeff);
        end
    end

    // Stage 3: the first product of a frame reloads, so frames can run back to back.
    always_ff @(posedge clock) begin
        if (reset) begin
            accum    <= '0;
            acc_done <= 1'b0;
        end else begin
            acc_done <= s2_valid && s2_last;
            if (s2_valid) begin
                accum <= s2_first ? ACCUM_WIDTH'(s2_product)
                                  : accum + ACCUM_WIDTH'(s2_product);
            end
        end
    end

    always_comb begin
        rounded       = round_shift(64'(accum), OUTPUT_SHIFT);
        next_overflow = !fits_signed(rounded, DATA_WIDTH);
`ifdef MAC_SATURATE_EN
        next_data     = DATA_WIDTH'(saturate(rounded, DATA_WIDTH));
`else
        next_data     = DATA_WIDTH'(rounded);
`endif
    end

    // Stage 4: results are captured only at frame end and held until the next one.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            carry_out <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= acc_done;
            if (acc_done) begin
                data_out  <= next_data;
                carry_out <= accum;
                overflow  <= next_overflow;
            end
        end
    end

endmodule

// File: tb/tb_multiply_accumulate_framed.sv
// Scoreboard bench for multiply_accumulate_framed: a frame-level reference model queues
// expected results at stimulus time and a negedge monitor checks each out_valid pulse.
module tb_multiply_accumulate_framed;

    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int AW    = 48;
    localparam int TAPS  = 8;
    localparam int SHIFT = 14;

    typedef struct {
        logic signed [DW-1:0] data;
        logic [AW-1:0]        carry;
        bit                   ovf;
        int                   cycle;
    } exp_t;

    logic                 clock = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] data_in;
    logic                 in_valid;
    logic                 in_last;
    logic                 coeff_write;
    logic [2:0]           coeff_address;
    logic signed [CW-1:0] coefficient_in;
    logic signed [DW-1:0] data_out;
    logic [AW-1:0]        carry_out;
    logic                 out_valid;
    logic                 overflow;

    exp_t                 sb[$];
    int                   errors = 0;
    int                   checks = 0;
    int                   cyc = 0;
    logic signed [CW-1:0] coef_model [TAPS];
    int                   model_tap = 0;
    longint               frame_sum = 0;
    logic signed [DW-1:0] hold_data = '0;
    logic [AW-1:0]        hold_carry = '0;
    bit                   hold_ovf = 1'b0;

    multiply_accumulate_framed #(
        .DATA_WIDTH        (DW),
        .COEFFICIENT_WIDTH (CW),
        .ACCUM_WIDTH       (AW),
        .NUM_TAPS          (TAPS),
        .OUTPUT_SHIFT      (SHIFT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data_in        (data_in),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .coeff_write    (coeff_write),
        .coeff_address  (coeff_address),
        .coefficient_in (coefficient_in),
        .data_out       (data_out),
        .carry_out      (carry_out),
        .out_valid      (out_valid),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    function automatic exp_t make_expected(input longint sum, input int when);
        exp_t   e;
        longint r;
        r       = (sum + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        e.ovf   = (r > 32767) || (r < -32768);
`ifdef MAC_SATURATE_EN
        if (r > 32767)       e.data = 16'sh7FFF;
        else if (r < -32768) e.data = 16'sh8000;
        else                 e.data = DW'(r);
`else
        e.data  = DW'(r);
`endif
        e.carry = AW'(sum);
        e.cycle = when;
        return e;
    endfunction

    // One clock of stimulus; the model reads the coefficient before this cycle's write lands.
    task automatic apply_stimulus(input bit v, input logic signed [DW-1:0] d, input bit last,
                                  input bit wr, input logic [2:0] a, input logic signed [CW-1:0] w);
        data_in        = d;
        in_valid       = v;
        in_last        = last;
        coeff_write    = wr;
        coeff_address  = a;
        coefficient_in = w;
        if (v) begin
            if (model_tap == 0) frame_sum = 0;
            frame_sum += longint'(d) * longint'(coef_model[model_tap]);
            if (last || model_tap == TAPS - 1) begin
                sb.push_back(make_expected(frame_sum, cyc + 4));
                model_tap = 0;
            end else begin
                model_tap++;
            end
        end
        if (wr) coef_model[a] = w;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset(input int n);
        in_valid    = 1'b0;
        in_last     = 1'b0;
        coeff_write = 1'b0;
        reset       = 1'b1;
        hold_data   = '0;
        hold_carry  = '0;
        hold_ovf    = 1'b0;
        model_tap   = 0;
        frame_sum   = 0;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_output();
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("latency", cyc, e.cycle);
                check("data_out", data_out, e.data);
                check("carry_out", carry_out, e.carry);
                check("overflow", overflow, e.ovf);
                hold_data  = e.data;
                hold_carry = e.carry;
                hold_ovf   = e.ovf;
            end
        end else begin
            check("hold_data_out", data_out, hold_data);
            check("hold_carry_out", carry_out, hold_carry);
            check("hold_overflow", overflow, hold_ovf);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) check_output();
    end

    initial begin
        int len;
        data_in        = '0;
        coeff_address  = '0;
        coefficient_in = '0;
        for (int i = 0; i < TAPS; i++) coef_model[i] = '0;
        apply_reset(3);

        check("reset_out_valid", out_valid, 0);
        check("reset_data_out", data_out, 0);
        check("reset_carry_out", carry_out, 0);
        check("reset_overflow", overflow, 0);

        for (int i = 0; i < TAPS; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b1, 3'(i), 16'sh4000);
        apply_stimulus(1'b1, 16'sd100, 1'b0, 1'b0, '0, '0);
        apply_stimulus(1'b1, 16'sd200, 1'b0, 1'b0, '0, '0);
        apply_stimulus(1'b1, 16'sd300, 1'b1, 1'b0, '0, '0);
        idle(6);

        // Coefficient 0 rewritten in the same cycle it is read for the first tap.
        apply_stimulus(1'b1, 16'sd10, 1'b1, 1'b1, 3'd0, 16'sh2000);
        idle(2);
        apply_stimulus(1'b1, 16'sd10, 1'b1, 1'b0, '0, '0);
        idle(5);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 3'd0, 16'sh4000);

        for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 16'(100 * (i + 1) - 400), 1'b0, 1'b0, '0, '0);
        apply_stimulus(1'b1, -16'sd77, 1'b1, 1'b0, '0, '0);
        idle(6);

        for (int i = 0; i < TAPS; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b1, 3'(i), 16'sh7FFF);
        for (int i = 0; i < TAPS; i++) apply_stimulus(1'b1, 16'sh7FFF, 1'b0, 1'b0, '0, '0);
        idle(6);

        apply_stimulus(1'b1, 16'sd1000, 1'b0, 1'b0, '0, '0);
        apply_stimulus(1'b1, 16'sd2000, 1'b0, 1'b0, '0, '0);
        apply_reset(2);
        apply_stimulus(1'b1, 16'sd3, 1'b0, 1'b0, '0, '0);
        apply_stimulus(1'b1, -16'sd5, 1'b0, 1'b0, '0, '0);
        apply_stimulus(1'b1, 16'sd7, 1'b1, 1'b0, '0, '0);
        idle(6);

        for (int i = 0; i < TAPS; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b1, 3'(i), 16'($urandom));
        for (int f = 0; f < 20; f++) begin
            for (int s = 0; s < 2; s++) begin
                idle($urandom_range(0, 2));
                apply_stimulus(1'b1, 16'($urandom), s == 1, 1'b0, '0, '0);
            end
        end
        idle(6);

        // Random lengths, including forced ends, with coefficient writes mixed in.
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 9);
            for (int s = 0; s < len; s++) begin
                idle($urandom_range(0, 1));
                apply_stimulus(1'b1, 16'($urandom), s == len - 1, $urandom_range(0, 3) == 0,
                               3'($urandom_range(0, 7)), 16'($urandom));
            end
        end
        idle(8);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiply_accumulate_framed.md
MULTIPLY_ACCUMULATE_FRAMED -- requirements
Module: multiply_accumulate_framed

Interface
REQ-001 Parameter DATA_WIDTH, 16, signed sample and result width.
REQ-002 Parameter COEFFICIENT_WIDTH, 16, signed coefficient width.
REQ-003 Parameter ACCUM_WIDTH, 48, accumulator width; must be at least DATA_WIDTH+COEFFICIENT_WIDTH+clog2(NUM_TAPS).
REQ-004 Parameter NUM_TAPS, 8, coefficient bank depth and maximum products per frame.
REQ-005 Parameter OUTPUT_SHIFT, 14, right shift applied to the accumulator at output.
REQ-006 Ports: clock  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 data_in  in  DATA_WIDTH  signed sample.
REQ-009 in_valid  in  1  data_in qualifier.
REQ-010 in_last  in  1  marks final sample of a frame; sampled only when in_valid=1.
REQ-011 coeff_write  in  1  coefficient bank write strobe.
REQ-012 coeff_address  in  clog2(NUM_TAPS)  bank write address.
REQ-013 coefficient_in  in  COEFFICIENT_WIDTH  signed write data.
REQ-014 data_out  out  DATA_WIDTH  rounded, scaled frame result.
REQ-015 carry_out  out  ACCUM_WIDTH  full-precision frame result.
REQ-016 out_valid  out  1  one-cycle pulse qualifying data_out/carry_out/overflow.
REQ-017 overflow  out  1  result exceeded DATA_WIDTH range.

Function
REQ-018 Tap counter selects coefficient; increments on each in_valid; returns to 0 after in_valid with in_last=1 or at tap NUM_TAPS-1 (forced frame end).
REQ-019 Pipeline: stage 1 registers sample and bank[tap]; stage 2 registers full-width signed product; stage 3 accumulates; stage 4 registers rounded/scaled output.
REQ-020 First product of a frame loads the accumulator; subsequent products add, sign-extended to ACCUM_WIDTH, two's-complement wrap in accumulator.
REQ-021 out_valid asserts exactly 4 cycles after the frame-ending in_valid cycle, for one cycle.
REQ-022 Gaps in in_valid are permitted; each stage advances only its own valid bit, no bubbles alter results.
REQ-023 Back-to-back frames (in_last followed next cycle by a new sample) produce independent results with no dead cycle.
REQ-024 Rounding: add 2^(OUTPUT_SHIFT-1) to carry_out then arithmetic shift right by OUTPUT_SHIFT (round half up).
REQ-025 Bank write and stage-1 read of the same address in one cycle: read returns the old value.
REQ-026 data_out, carry_out, overflow hold their value between out_valid pulses.

Reset
REQ-027 Reset clears tap counter, all pipeline valid bits, accumulator, carry_out, data_out, overflow, out_valid to 0.
REQ-028 Coefficient bank is not cleared by reset; contents persist.
REQ-029 Reset mid-frame discards the partial frame; no out_valid for it; next sample starts tap 0.

Configuration
REQ-030 Macro MAC_SATURATE_EN defined: rounded result outside signed DATA_WIDTH range clamps to max/min and sets overflow=1.
REQ-031 Macro undefined: data_out is the low DATA_WIDTH bits of the rounded result (wrap); overflow still reports range exceedance.

Structure
REQ-032 Shared package mac_pkg holds the round/saturate function and the signed min/max constants per width.
REQ-033 One sub-module, mac_coefficient_bank: NUM_TAPS x COEFFICIENT_WIDTH, one write port, one registered read port.

Verification (OUTPUT_SHIFT=14, NUM_TAPS=8 unless stated)
REQ-034 All coeffs 0x4000; samples 100,200,300 with in_last on 300 -> data_out=600, carry_out=600<<14, overflow=0, 4 cycles after last.
REQ-035 Coeffs 0x7FFF, eight samples 0x7FFF -> with MAC_SATURATE_EN data_out=0x7FFF, overflow=1; without, data_out = low 16 bits of rounded sum, overflow=1.
REQ-036 Nine samples without in_last -> forced end after 8th, one result; 9th sample starts new frame at tap 0.
REQ-037 Reset asserted after 2 of 4 samples, then a full 3-sample frame -> only the 3-sample result appears, correct value.
REQ-038 Write coeff[0]=0x2000 in same cycle as tap-0 read of old 0x4000, sample 10 last -> data_out=10; next frame sample 10 -> data_out=5.
REQ-039 Frames of 2 samples back-to-back with random in_valid gaps -> each result matches reference model, one out_valid per frame.
